// File: rtl/riscv_axi_pkg.sv
// Shared constants and helpers for the RISC-V AXI master bridge.
package riscv_axi_pkg;

  typedef enum logic {
    SRC_DATA = 1'b0,
    SRC_INST = 1'b1
  } axi_src_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI size code for a full-width single beat.
  function automatic logic [2:0] axi_size_f(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/axi_out_ctr.sv
// Outstanding-transaction counter, 0..MAX_OUT, with full/empty flags.
module axi_out_ctr #(
  parameter int MAX_OUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          up;
  logic          dn;

  assign full_o  = (cnt_q == CW'(MAX_OUT));
  assign empty_o = (cnt_q == '0);

  // A decrement at zero is a stray response and is ignored.
  assign up = inc_i & ~full_o;
  assign dn = dec_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({up, dn})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/riscv_axi_master.sv
// Fetch/data to AXI3-subset bridge with per-source outstanding
// tracking and fixed-priority read-address arbitration.
module riscv_axi_master
  import riscv_axi_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_ready,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_wdone,
  output logic                dm_err,

  output logic [ID_W-1:0]     aw_id,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [3:0]          aw_len,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                aw_valid,
  input  logic                aw_ready,

  output logic [ID_W-1:0]     w_id,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  output logic                w_valid,
  input  logic                w_ready,

  input  logic [ID_W-1:0]     b_id,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready,

  output logic [ID_W-1:0]     ar_id,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [3:0]          ar_len,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  output logic                ar_valid,
  input  logic                ar_ready,

  input  logic [ID_W-1:0]     r_id,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  input  logic                r_valid,
  output logic                r_ready
);

  localparam int SW = DATA_W / 8;
  localparam logic [ID_W-1:0] ID_INST = {SRC_INST, {(ID_W-1){1'b0}}};
  localparam logic [ID_W-1:0] ID_DATA = {SRC_DATA, {(ID_W-1){1'b0}}};

  logic              if_v_q, if_v_d;
  logic [ADDR_W-1:0] if_a_q, if_a_d;
  logic              dr_v_q, dr_v_d;
  logic [ADDR_W-1:0] dr_a_q, dr_a_d;
  logic              aw_v_q, aw_v_d;
  logic              w_v_q, w_v_d;
  logic [ADDR_W-1:0] aw_a_q, aw_a_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [SW-1:0]     ws_q, ws_d;

  logic              ifr_v_q, ifr_v_d;
  logic [DATA_W-1:0] ifr_d_q, ifr_d_d;
  logic              ifr_e_q, ifr_e_d;
  logic              dmr_v_q, dmr_v_d;
  logic [DATA_W-1:0] dmr_d_q, dmr_d_d;
  logic              wdn_q, wdn_d;
  logic              dme_q, dme_d;

  logic if_full, if_empty;
  logic dr_full, dr_empty;
  logic dw_full, dw_empty;

  logic ar_hs, if_gnt;
  logic if_free, dr_free, st_free;
  logic ld_ok, st_ok;
  logic if_acc, ld_acc, st_acc;
  logic r_inst, r_dat;
  logic if_rsp, dr_rsp, b_rsp;
  logic unused_ok;

  assign unused_ok = ^{r_last, b_id, r_id[ID_W-2:0]};

  // Data slot has priority on the shared AR channel.
  assign if_gnt   = if_v_q & ~dr_v_q;
  assign ar_valid = dr_v_q | if_v_q;
  assign ar_id    = dr_v_q ? ID_DATA : ID_INST;
  assign ar_addr  = dr_v_q ? dr_a_q : if_a_q;
  assign ar_len   = 4'd0;
  assign ar_size  = axi_size_f(DATA_W);
  assign ar_burst = AXI_BURST_INCR;
  assign ar_hs    = ar_valid & ar_ready;

  assign aw_id    = ID_DATA;
  assign aw_addr  = aw_a_q;
  assign aw_len   = 4'd0;
  assign aw_size  = axi_size_f(DATA_W);
  assign aw_burst = AXI_BURST_INCR;
  assign aw_valid = aw_v_q;
  assign w_id     = ID_DATA;
  assign w_data   = wd_q;
  assign w_strb   = ws_q;
  assign w_last   = 1'b1;
  assign w_valid  = w_v_q;

  assign r_ready  = 1'b1;
  assign b_ready  = 1'b1;

  // Slot readiness looks at next-state emptiness for back-to-back issue.
  assign if_free  = ~if_v_q | (ar_hs & if_gnt);
  assign dr_free  = ~dr_v_q | ar_hs;
  assign st_free  = (~aw_v_q | aw_ready) & (~w_v_q | w_ready);

  assign if_ready = if_free & ~if_full;
  assign ld_ok    = dr_free & ~dr_full & dw_empty;
  assign st_ok    = st_free & ~dw_full & dr_empty;
  assign dm_ready = dm_we ? st_ok : ld_ok;

  assign if_acc   = if_req & if_ready;
  assign ld_acc   = dm_req & ~dm_we & ld_ok;
  assign st_acc   = dm_req & dm_we & st_ok;

  assign r_inst   = r_valid & r_id[ID_W-1];
  assign r_dat    = r_valid & ~r_id[ID_W-1];
  assign if_rsp   = r_inst & ~if_empty;
  assign dr_rsp   = r_dat & ~dr_empty;
  assign b_rsp    = b_valid & ~dw_empty;

  axi_out_ctr #(.MAX_OUT(MAX_OUT)) u_ctr_if (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (if_acc),
    .dec_i  (r_inst),
    .full_o (if_full),
    .empty_o(if_empty)
  );

  axi_out_ctr #(.MAX_OUT(MAX_OUT)) u_ctr_dr (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (ld_acc),
    .dec_i  (r_dat),
    .full_o (dr_full),
    .empty_o(dr_empty)
  );

  axi_out_ctr #(.MAX_OUT(MAX_OUT)) u_ctr_dw (
    .clk    (clk),
    .reset  (reset),
    .inc_i  (st_acc),
    .dec_i  (b_valid),
    .full_o (dw_full),
    .empty_o(dw_empty)
  );

  always_comb begin
    if_v_d  = if_v_q;
    if_a_d  = if_a_q;
    dr_v_d  = dr_v_q;
    dr_a_d  = dr_a_q;
    aw_v_d  = aw_v_q;
    w_v_d   = w_v_q;
    aw_a_d  = aw_a_q;
    wd_d    = wd_q;
    ws_d    = ws_q;
    ifr_d_d = ifr_d_q;
    dmr_d_d = dmr_d_q;

    if (ar_hs & if_gnt) if_v_d = 1'b0;
    if (ar_hs & dr_v_q) dr_v_d = 1'b0;
    if (aw_v_q & aw_ready) aw_v_d = 1'b0;
    if (w_v_q & w_ready) w_v_d = 1'b0;

    if (if_acc) begin
      if_v_d = 1'b1;
      if_a_d = if_addr;
    end
    if (ld_acc) begin
      dr_v_d = 1'b1;
      dr_a_d = dm_addr;
    end
    if (st_acc) begin
      aw_v_d = 1'b1;
      w_v_d  = 1'b1;
      aw_a_d = dm_addr;
      wd_d   = dm_wdata;
      ws_d   = dm_wstrb;
    end

    ifr_v_d = if_rsp;
    ifr_e_d = if_rsp & (r_resp != AXI_RESP_OKAY);
    dmr_v_d = dr_rsp;
    wdn_d   = b_rsp;
    dme_d   = (dr_rsp & (r_resp != AXI_RESP_OKAY))
            | (b_rsp & (b_resp != AXI_RESP_OKAY));
    if (if_rsp) ifr_d_d = r_data;
    if (dr_rsp) dmr_d_d = r_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_v_q  <= 1'b0;
      if_a_q  <= '0;
      dr_v_q  <= 1'b0;
      dr_a_q  <= '0;
      aw_v_q  <= 1'b0;
      w_v_q   <= 1'b0;
      aw_a_q  <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
      ifr_v_q <= 1'b0;
      ifr_d_q <= '0;
      ifr_e_q <= 1'b0;
      dmr_v_q <= 1'b0;
      dmr_d_q <= '0;
      wdn_q   <= 1'b0;
      dme_q   <= 1'b0;
    end else begin
      if_v_q  <= if_v_d;
      if_a_q  <= if_a_d;
      dr_v_q  <= dr_v_d;
      dr_a_q  <= dr_a_d;
      aw_v_q  <= aw_v_d;
      w_v_q   <= w_v_d;
      aw_a_q  <= aw_a_d;
      wd_q    <= wd_d;
      ws_q    <= ws_d;
      ifr_v_q <= ifr_v_d;
      ifr_d_q <= ifr_d_d;
      ifr_e_q <= ifr_e_d;
      dmr_v_q <= dmr_v_d;
      dmr_d_q <= dmr_d_d;
      wdn_q   <= wdn_d;
      dme_q   <= dme_d;
    end
  end

  assign if_rvalid = ifr_v_q;
  assign if_rdata  = ifr_d_q;
  assign if_err    = ifr_e_q;
  assign dm_rvalid = dmr_v_q;
  assign dm_rdata  = dmr_d_q;
  assign dm_wdone  = wdn_q;
  assign dm_err    = dme_q;

endmodule

// File: tb/tb_riscv_axi_master.sv
// Directed bench for riscv_axi_master with a hand-driven AXI slave.
module tb_riscv_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ready, dm_rvalid, dm_wdone, dm_err;
  logic [31:0] dm_rdata;
  logic [3:0]  aw_id, aw_len;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid, aw_ready;
  logic [3:0]  w_id, w_strb;
  logic [31:0] w_data;
  logic        w_last, w_valid, w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid, b_ready;
  logic [3:0]  ar_id, ar_len;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid, ar_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last, r_valid, r_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_axi_master dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb), .dm_ready(dm_ready),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_wdone(dm_wdone), .dm_err(dm_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_id(w_id), .w_data(w_data), .w_strb(w_strb),
    .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, checks 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rbeat(input logic [3:0] id, input logic [31:0] d,
                       input logic [1:0] rs);
    r_valid = 1'b1; r_id = id; r_data = d; r_resp = rs;
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_wstrb = 0;
    aw_ready = 0; w_ready = 0; ar_ready = 0;
    b_id = 0; b_resp = 0; b_valid = 0;
    r_id = 0; r_data = 0; r_resp = 0; r_last = 1; r_valid = 0;
    repeat (3) tick();
    reset = 1'b0;
    settle();

    // Reset state
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_aw_valid", aw_valid, 0);
    chk("rst_w_valid", w_valid, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_dm_rvalid", dm_rvalid, 0);
    chk("rst_dm_wdone", dm_wdone, 0);
    chk("rst_dm_err", dm_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_dm_ready", dm_ready, 1);
    chk("rst_r_ready", r_ready, 1);
    chk("rst_b_ready", b_ready, 1);

    // Single fetch
    tick();
    if_req = 1; if_addr = 32'h0000_0100;
    settle();
    chk("f1_if_ready", if_ready, 1);
    tick();
    if_req = 0;
    settle();
    chk("f1_ar_valid", ar_valid, 1);
    chk("f1_ar_id", ar_id, 4'b1000);
    chk("f1_ar_addr", ar_addr, 32'h100);
    chk("f1_ar_len", ar_len, 0);
    chk("f1_ar_size", ar_size, 3'd2);
    chk("f1_ar_burst", ar_burst, 2'b01);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    settle();
    chk("f1_ar_drop", ar_valid, 0);
    tick();
    tick();
    rbeat(4'b1000, 32'h0000_0013, 2'b00);
    tick();
    r_valid = 0;
    settle();
    chk("f1_if_rvalid", if_rvalid, 1);
    chk("f1_if_rdata", if_rdata, 32'h13);
    chk("f1_if_err", if_err, 0);
    chk("f1_dm_rvalid", dm_rvalid, 0);
    tick();
    chk("f1_pulse_end", if_rvalid, 0);

    // Arbitration: data wins
    if_req = 1; if_addr = 32'h200;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    tick();
    if_req = 0; dm_req = 0;
    settle();
    chk("arb_first_id", ar_id, 4'b0000);
    chk("arb_first_addr", ar_addr, 32'h300);
    ar_ready = 1;
    tick();
    settle();
    chk("arb_second_valid", ar_valid, 1);
    chk("arb_second_id", ar_id, 4'b1000);
    chk("arb_second_addr", ar_addr, 32'h200);
    tick();
    ar_ready = 0;
    settle();
    chk("arb_drained", ar_valid, 0);
    rbeat(4'b0000, 32'hAAAA_0001, 2'b00);
    tick();
    rbeat(4'b1000, 32'hBBBB_0002, 2'b00);
    settle();
    chk("arb_dm_rvalid", dm_rvalid, 1);
    chk("arb_dm_rdata", dm_rdata, 32'hAAAA_0001);
    chk("arb_if_quiet", if_rvalid, 0);
    tick();
    r_valid = 0;
    settle();
    chk("arb_if_rvalid", if_rvalid, 1);
    chk("arb_if_rdata", if_rdata, 32'hBBBB_0002);
    chk("arb_dm_quiet", dm_rvalid, 0);
    tick();

    // Store then load to same address
    dm_req = 1; dm_we = 1; dm_addr = 32'h400;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b1111;
    settle();
    chk("st_ready", dm_ready, 1);
    tick();
    dm_we = 0;
    settle();
    chk("st_aw_valid", aw_valid, 1);
    chk("st_w_valid", w_valid, 1);
    chk("st_aw_addr", aw_addr, 32'h400);
    chk("st_aw_id", aw_id, 0);
    chk("st_w_data", w_data, 32'hDEAD_BEEF);
    chk("st_w_strb", w_strb, 4'b1111);
    chk("st_w_last", w_last, 1);
    chk("ld_blocked0", dm_ready, 0);
    aw_ready = 1; w_ready = 1;
    tick();
    aw_ready = 0; w_ready = 0;
    settle();
    chk("st_aw_done", aw_valid, 0);
    chk("st_w_done", w_valid, 0);
    chk("ld_blocked1", dm_ready, 0);
    tick();
    b_valid = 1; b_resp = 2'b00;
    settle();
    chk("ld_blocked_b", dm_ready, 0);
    tick();
    b_valid = 0;
    settle();
    chk("st_wdone", dm_wdone, 1);
    chk("st_err", dm_err, 0);
    chk("ld_unblocked", dm_ready, 1);
    tick();
    dm_req = 0;
    settle();
    chk("ld_ar_valid", ar_valid, 1);
    chk("ld_ar_addr", ar_addr, 32'h400);
    chk("ld_ar_id", ar_id, 0);
    chk("ld_wdone_end", dm_wdone, 0);
    ar_ready = 1;
    tick();
    ar_ready = 0;
    // Load error response
    rbeat(4'b0000, 32'h0000_0055, 2'b10);
    tick();
    r_valid = 0; r_resp = 0;
    settle();
    chk("err_dm_rvalid", dm_rvalid, 1);
    chk("err_dm_err", dm_err, 1);
    chk("err_dm_rdata", dm_rdata, 32'h55);
    tick();
    chk("err_pulse_end", dm_err, 0);

    // Independent AW/W handshakes
    dm_req = 1; dm_we = 1; dm_addr = 32'h500;
    dm_wdata = 32'h1234_5678; dm_wstrb = 4'b0011;
    tick();
    dm_addr = 32'h504; dm_wdata = 32'h0BAD_F00D;
    aw_ready = 1;
    settle();
    chk("aw_split_blk0", dm_ready, 0);
    tick();
    aw_ready = 0;
    settle();
    chk("aw_split_aw", aw_valid, 0);
    chk("aw_split_w", w_valid, 1);
    chk("aw_split_blk1", dm_ready, 0);
    tick();
    settle();
    chk("aw_split_w_hold", w_valid, 1);
    chk("aw_split_data", w_data, 32'h1234_5678);
    w_ready = 1;
    settle();
    chk("aw_split_b2b", dm_ready, 1);
    tick();
    w_ready = 0; dm_req = 0;
    settle();
    chk("st2_aw_valid", aw_valid, 1);
    chk("st2_w_valid", w_valid, 1);
    chk("st2_aw_addr", aw_addr, 32'h504);
    aw_ready = 1; w_ready = 1;
    tick();
    aw_ready = 0; w_ready = 0;
    b_valid = 1; b_resp = 2'b00;
    tick();
    b_resp = 2'b10;
    settle();
    chk("st2_wdone_a", dm_wdone, 1);
    chk("st2_err_a", dm_err, 0);
    tick();
    b_valid = 0; b_resp = 0;
    settle();
    chk("st2_wdone_b", dm_wdone, 1);
    chk("st2_err_b", dm_err, 1);
    tick();

    // Outstanding limit
    ar_ready = 1;
    if_req = 1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'h1000 + 32'(4 * i);
      settle();
      chk($sformatf("lim_ready%0d", i), if_ready, 1);
      tick();
    end
    if_addr = 32'h1010;
    settle();
    chk("lim_full", if_ready, 0);
    chk("lim_ar4_addr", ar_addr, 32'h100C);
    tick();
    settle();
    chk("lim_ar_empty", ar_valid, 0);
    chk("lim_still_full", if_ready, 0);
    rbeat(4'b1000, 32'h0000_0001, 2'b00);
    settle();
    chk("lim_full_at_r", if_ready, 0);
    tick();
    r_valid = 0;
    settle();
    chk("lim_reopen", if_ready, 1);
    chk("lim_rvalid", if_rvalid, 1);
    tick();
    if_req = 0;
    settle();
    chk("lim_5th_valid", ar_valid, 1);
    chk("lim_5th_addr", ar_addr, 32'h1010);
    tick();
    ar_ready = 0;
    rbeat(4'b1000, 32'h2, 2'b00);
    tick();
    rbeat(4'b1000, 32'h3, 2'b00);
    tick();
    r_valid = 0;
    tick();

    // Reset with two fetches outstanding
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("rr_if_ready", if_ready, 1);
    chk("rr_if_rvalid", if_rvalid, 0);
    chk("rr_if_rdata", if_rdata, 0);
    rbeat(4'b1000, 32'hCAFE_0001, 2'b00);
    tick();
    settle();
    chk("rr_late1", if_rvalid, 0);
    rbeat(4'b1000, 32'hCAFE_0002, 2'b00);
    tick();
    r_valid = 0;
    settle();
    chk("rr_late2", if_rvalid, 0);
    chk("rr_rdata", if_rdata, 0);
    // Counter must be back at zero: exactly four fetches fit
    ar_ready = 1; if_req = 1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'h2000 + 32'(4 * i);
      settle();
      chk($sformatf("rr_fill%0d", i), if_ready, 1);
      tick();
    end
    settle();
    chk("rr_full", if_ready, 0);
    if_req = 0; ar_ready = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
